csa_acc_seq: RTL and testbench

CSA_ACC_SEQ -- requirements
Module: csa_acc_seq

---
 rtl/csa_acc_pkg.sv | 14 +
 rtl/csa_acc_seq_csa.sv | 16 +
 rtl/csa_acc_seq.sv | 107 ++++++++++
 tb/tb_csa_acc_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the carry-save accumulator.
// CSA_W is the operand and datapath width.
package csa_acc_pkg;

   localparam int CSA_W = 20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACC     = 2'd1,
      RESOLVE = 2'd2,
      OUT     = 2'd3
   } state_t;

endpackage

// File: rtl/csa_acc_seq_csa.sv
// csa_20: 20-bit 3:2 carry-save compressor.
// carry[i] carries weight 2^(i+1) relative to sum[i].
module csa_20
   import csa_acc_pkg::*;
(
   input  logic [CSA_W-1:0] x,
   input  logic [CSA_W-1:0] y,
   input  logic [CSA_W-1:0] z,
   output logic [CSA_W-1:0] sum,
   output logic [CSA_W-1:0] carry
);

   assign sum   = x ^ y ^ z;
   assign carry = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_acc_seq.sv
// Group accumulator holding its total in carry-save form, resolved before output.
// Define CSA_ACC_SEQ_OVF_EN to enable the sticky overflow flag on out_ovf.
module csa_acc_seq
   import csa_acc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CSA_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CSA_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   state_t           state;
   logic [CSA_W-1:0] s_q;
   logic [CSA_W-1:0] c_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CSA_W-1:0] y_sh;
   logic [CSA_W-1:0] z_in;
   logic [CSA_W-1:0] s_nxt;
   logic [CSA_W-1:0] c_nxt;
   logic             accept;
   logic             resolved;
   logic             upd;
   logic             done;

   assign y_sh     = {c_q[CSA_W-2:0], 1'b0};
   assign z_in     = (state == RESOLVE) ? '0 : in_data;
   assign in_ready = (state == IDLE) || (state == ACC);
   assign accept   = in_valid && in_ready;
   assign resolved = (y_sh == '0);
   assign upd      = accept || ((state == RESOLVE) && !resolved);
   assign done     = (state == OUT) && out_ready;

   csa_20 u_csa (
      .x     (s_q),
      .y     (y_sh),
      .z     (z_in),
      .sum   (s_nxt),
      .carry (c_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE, ACC: if (accept) state <= in_last ? RESOLVE : ACC;
            RESOLVE:   if (resolved) state <= OUT;
            OUT:       if (out_ready) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // c_nxt[CSA_W-1] falls off the top: its weight is beyond the result width
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else if (done) begin
         s_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else begin
         if (upd) begin
            s_q <= s_nxt;
            c_q <= c_nxt;
         end
         if (accept && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef CSA_ACC_SEQ_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (done) begin
         ovf_q <= 1'b0;
      end else if (upd) begin
         ovf_q <= ovf_q | c_nxt[CSA_W-1];
      end
   end

   assign out_ovf = ovf_q;
`else
   logic unused_c_top;

   assign unused_c_top = c_nxt[CSA_W-1];
   assign out_ovf      = 1'b0;
`endif

   assign out_valid = (state == OUT);
   assign out_sum   = s_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_acc_seq.sv
// Scoreboard bench for csa_acc_seq: groups in, resolved sums out.
// Expected ovf follows CSA_ACC_SEQ_OVF_EN.
module tb_csa_acc_seq;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [19:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [19:0]      out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   typedef struct {
      logic [19:0]      sum;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
      int               lat;
   } exp_t;

   exp_t        sb[$];
   logic [19:0] ops[$];
   int          n_tot = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   csa_acc_seq #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
      end
   endtask

   // reference: true sum of the group, independent of carry-save form
   task automatic push_exp(input int lat);
      exp_t    e;
      longint  t;
      t = 0;
      foreach (ops[i]) t += longint'(ops[i]);
      e.sum = t[19:0];
      e.cnt = (ops.size() > 255) ? 8'hFF : CNT_W'(ops.size());
`ifdef CSA_ACC_SEQ_OVF_EN
      e.ovf = (t >= 64'h100000);
`else
      e.ovf = 1'b0;
`endif
      e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic drive_group();
      int w;
      foreach (ops[i]) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = ops[i];
         in_last  = (i == ops.size() - 1);
         w = 0;
         while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready) chk("in_ready_timeout", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic take_result(input bit stall);
      int         lat;
      exp_t       e;
      logic [19:0] hs;
      logic [7:0]  hc;
      logic        ho;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         chk("out_valid_timeout", out_valid, 1);
         return;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      chk("sum", out_sum, e.sum);
      chk("count", out_count, e.cnt);
      chk("ovf", out_ovf, e.ovf);
      if (e.lat >= 0) chk("latency", lat, e.lat);
      if (stall) begin
         hs = out_sum;
         hc = out_count;
         ho = out_ovf;
         for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 20'($urandom);
            in_last  = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_sum", out_sum, hs);
            chk("stall_count", out_count, hc);
            chk("stall_ovf", out_ovf, ho);
            chk("stall_in_ready", in_ready, 0);
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      // single operand, k = 0
      ops = {20'h12345};
      push_exp(1);
      drive_group();
      take_result(0);

      ops = {20'h1, 20'h2, 20'h3};
      push_exp(-1);
      drive_group();
      take_result(0);

      // carry ripples through all bits: k = 19
      ops = {20'hFFFFF, 20'h00001};
      push_exp(20);
      drive_group();
      take_result(0);

      // output stall with in_valid asserted
      ops = {20'h80000, 20'h80000, 20'h00007};
      push_exp(-1);
      drive_group();
      take_result(1);

      // counter saturation
      ops.delete();
      for (int i = 0; i < 300; i++) ops.push_back(20'h00001);
      push_exp(-1);
      drive_group();
      take_result(0);

      for (int g = 0; g < 4; g++) begin
         ops.delete();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++)
            ops.push_back(20'($urandom));
         push_exp(-1);
         drive_group();
         take_result(0);
      end

      // reset mid-RESOLVE discards the group
      ops = {20'hFFFFF, 20'h00001};
      drive_group();
      repeat (3) @(negedge clk);
      chk("resolve_in_ready", in_ready, 0);
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      ops = {20'h00010};
      push_exp(1);
      drive_group();
      take_result(0);

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
